// File: rtl/if_id_stage_pkg.sv
// Shared sign-extender format codes, RV32 opcode constants and decode record
// for the IF/ID pipeline register.
`ifndef IF_ID_STAGE_DEFINES
`define IF_ID_STAGE_DEFINES
`define SEXT_I    3'b000
`define SEXT_S    3'b001
`define SEXT_B    3'b010
`define SEXT_U    3'b011
`define SEXT_J    3'b100
// Unused code: the sign extender's default path yields 0 for it.
`define SEXT_NONE 3'b111

`define OP_IMM    7'b0010011
`define OP_LOAD   7'b0000011
`define OP_JALR   7'b1100111
`define OP_STORE  7'b0100011
`define OP_BRANCH 7'b1100011
`define OP_LUI    7'b0110111
`define OP_AUIPC  7'b0010111
`define OP_JAL    7'b1101111
`define OP_REG    7'b0110011
`endif

package if_id_stage_pkg;
  localparam logic [2:0] SEXT_I    = `SEXT_I;
  localparam logic [2:0] SEXT_S    = `SEXT_S;
  localparam logic [2:0] SEXT_B    = `SEXT_B;
  localparam logic [2:0] SEXT_U    = `SEXT_U;
  localparam logic [2:0] SEXT_J    = `SEXT_J;
  localparam logic [2:0] SEXT_NONE = `SEXT_NONE;

  typedef struct packed {
    logic [2:0] sext_op;
    logic       rs1_used;
    logic       rs2_used;
    logic       rd_valid;
    logic       illegal;
  } inst_class_t;
endpackage

// File: rtl/if_id_stage_classify.sv
// Combinational opcode classifier feeding the IF/ID load path: immediate
// format, register-use flags and illegal-opcode detection.
module inst_classify
  import if_id_stage_pkg::*;
(
  input  logic [31:0] inst,
  output logic [2:0]  sext_op,
  output logic        rs1_used,
  output logic        rs2_used,
  output logic        rd_valid,
  output logic        illegal
);

  inst_class_t cls;
  logic        unused_hi;

  assign unused_hi = ^inst[31:7];

  always_comb begin
    cls = '{sext_op: `SEXT_NONE, rs1_used: 1'b0, rs2_used: 1'b0,
            rd_valid: 1'b0, illegal: 1'b1};
    case (inst[6:0])
      `OP_IMM, `OP_LOAD, `OP_JALR:
        cls = '{`SEXT_I,    1'b1, 1'b0, 1'b1, 1'b0};
      `OP_STORE:
        cls = '{`SEXT_S,    1'b1, 1'b1, 1'b0, 1'b0};
      `OP_BRANCH:
        cls = '{`SEXT_B,    1'b1, 1'b1, 1'b0, 1'b0};
      `OP_LUI, `OP_AUIPC:
        cls = '{`SEXT_U,    1'b0, 1'b0, 1'b1, 1'b0};
      `OP_JAL:
        cls = '{`SEXT_J,    1'b0, 1'b0, 1'b1, 1'b0};
      `OP_REG:
        cls = '{`SEXT_NONE, 1'b1, 1'b1, 1'b1, 1'b0};
      default: ;
    endcase
  end

  assign sext_op  = cls.sext_op;
  assign rs1_used = cls.rs1_used;
  assign rs2_used = cls.rs2_used;
  assign rd_valid = cls.rd_valid;
  assign illegal  = cls.illegal;

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with registered opcode decode for the ID stage.
// Optional IF_ID_PERF_EN adds saturating stall/flush event counters.
module if_id_stage
  import if_id_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  input  logic        if_valid,
  input  logic [31:0] if_pc,
  input  logic [31:0] if_inst,
  input  logic        id_stall,
  input  logic        id_flush,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4,
  output logic [31:0] id_inst,
  output logic [2:0]  id_sext_op,
  output logic [24:0] id_sext_din,
  output logic [4:0]  id_rs1,
  output logic [4:0]  id_rs2,
  output logic [4:0]  id_rd,
  output logic        id_rs1_used,
  output logic        id_rs2_used,
  output logic        id_illegal,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
);

  logic [2:0] c_sext_op;
  logic       c_rs1_used;
  logic       c_rs2_used;
  logic       c_rd_valid;
  logic       c_illegal;
  logic       load_bubble;

  inst_classify u_classify (
    .inst     (if_inst),
    .sext_op  (c_sext_op),
    .rs1_used (c_rs1_used),
    .rs2_used (c_rs2_used),
    .rd_valid (c_rd_valid),
    .illegal  (c_illegal)
  );

  assign load_bubble = cpu_rst || id_flush || (!id_stall && !if_valid);

  // Bubble fields are the decode of NOP_INST (addi x0,x0,0).
  always_ff @(posedge cpu_clk) begin
    if (load_bubble) begin
      id_valid    <= 1'b0;
      id_pc       <= RESET_PC;
      id_pc4      <= RESET_PC + 32'd4;
      id_inst     <= NOP_INST;
      id_sext_op  <= `SEXT_I;
      id_sext_din <= NOP_INST[31:7];
      id_rs1      <= 5'd0;
      id_rs2      <= 5'd0;
      id_rd       <= 5'd0;
      id_rs1_used <= 1'b1;
      id_rs2_used <= 1'b0;
      id_illegal  <= 1'b0;
    end else if (!id_stall) begin
      id_valid    <= 1'b1;
      id_pc       <= if_pc;
      id_pc4      <= if_pc + 32'd4;
      id_inst     <= if_inst;
      id_sext_op  <= c_sext_op;
      id_sext_din <= if_inst[31:7];
      id_rs1      <= if_inst[19:15];
      id_rs2      <= if_inst[24:20];
      id_rd       <= c_rd_valid ? if_inst[11:7] : 5'd0;
      id_rs1_used <= c_rs1_used;
      id_rs2_used <= c_rs2_used;
      id_illegal  <= c_illegal;
    end
  end

`ifdef IF_ID_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (id_stall && !id_flush && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + 32'd1;
      if (id_flush && (flush_cnt_q != '1))
        flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`else
  assign perf_stall_cnt = '0;
  assign perf_flush_cnt = '0;
`endif

endmodule
